// File: rtl/div_sequencer_if.sv
// Divider-core request/response bundle.
// The sequencer drives the master side and the divider core drives the slave side.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            core_req;
  logic            core_ready;
  logic            core_signed;
  logic [XLEN-1:0] core_dividend;
  logic [XLEN-1:0] core_divisor;
  logic            core_done;
  logic [XLEN-1:0] core_quotient;
  logic [XLEN-1:0] core_remainder;

  modport master (
    output core_req, core_signed, core_dividend, core_divisor,
    input  core_ready, core_done, core_quotient, core_remainder
  );

  modport slave (
    input  core_req, core_signed, core_dividend, core_divisor,
    output core_ready, core_done, core_quotient, core_remainder
  );
endinterface

// File: rtl/div_sequencer.sv
// EX-stage control for RISC-V DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow locally and sequences every other op through the divider core.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_is_div,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic             flush,
  output logic             stall,
  output logic [XLEN-1:0]  result,
  output logic             result_valid,
  div_sequencer_if.master  core,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t state;
  logic   is_rem;
  logic   go;
  logic   handshake;
  logic   launch_signed;
  logic   div_zero;
  logic   sgn_ovf;

  // Core handshake: core_req is a valid. Once raised it stays high with
  // stable operands until core_ready is seen high on a rising edge; it
  // drops only then, on flush, or on reset.
  assign go            = ex_valid & ex_is_div & funct3[2] & ~flush;
  assign handshake     = core.core_req & core.core_ready;
  assign launch_signed = ~funct3[0];
  assign div_zero      = (rs2_val == '0);
  assign sgn_ovf       = launch_signed & (rs1_val == INT_MIN) & (rs2_val == ALL_ONES);

  always_comb begin
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE:    stall = go;
      ISSUE:   stall = 1'b1;
      WAIT:    stall = 1'b1;
      DONE:    result_valid = ~flush;
      DRAIN:   stall = ex_valid & ex_is_div;
      default: stall = 1'b0;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      result             <= '0;
      is_rem             <= 1'b0;
      core.core_req      <= 1'b0;
      core.core_signed   <= 1'b0;
      core.core_dividend <= '0;
      core.core_divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            core.core_dividend <= rs1_val;
            core.core_divisor  <= rs2_val;
            core.core_signed   <= launch_signed;
            is_rem             <= funct3[1];
            if (div_zero) begin
              result <= funct3[1] ? rs1_val : ALL_ONES;
              state  <= DONE;
            end else if (sgn_ovf) begin
              result <= funct3[1] ? '0 : INT_MIN;
              state  <= DONE;
            end else begin
              core.core_req <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A request accepted on the flush cycle still has a result coming back.
          if (flush) begin
            core.core_req <= 1'b0;
            state         <= handshake ? DRAIN : IDLE;
          end else if (handshake) begin
            core.core_req <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= core.core_done ? IDLE : DRAIN;
          end else if (core.core_done) begin
            result <= is_rem ? core.core_remainder : core.core_quotient;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          if (core.core_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed vectors, scripted divider core,
// and a result scoreboard fed at the cycle a result is due.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_is_div;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic [2:0]  dbg_state;

  div_sequencer_if #(.XLEN(32)) core_if ();

  div_sequencer #(.XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_is_div    (ex_is_div),
    .funct3       (funct3),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .flush        (flush),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .core         (core_if),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          hs_count     = 0;
  logic [31:0] last_hs_dividend = '0;
  logic [31:0] last_result  = '0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // monitor: counts handshakes, scores every result_valid pulse
  always @(negedge clk) begin
    if (reset_n && core_if.core_req && core_if.core_ready) begin
      hs_count++;
      last_hs_dividend = core_if.core_dividend;
    end
    if (result_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_result_valid", {31'b0, result_valid}, 32'd0);
      else check_eq("scoreboard_result", result, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one op through the core path; starts and ends at posedge+1 of an IDLE cycle
  task automatic run_core(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int rdy_wait, input int done_wait,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic [31:0] exp_res, input logic exp_sgn);
    int hs0;
    hs0 = hs_count;
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    core_if.core_ready = 1'b0;
    @(negedge clk); check_eq({tag, "_stall_launch"}, {31'b0, stall}, 32'd1);
    tick();
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      check_eq({tag, "_req_held"}, {31'b0, core_if.core_req}, 32'd1);
      check_eq({tag, "_dividend_held"}, core_if.core_dividend, a);
      tick();
    end
    core_if.core_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_req"}, {31'b0, core_if.core_req}, 32'd1);
    check_eq({tag, "_signed"}, {31'b0, core_if.core_signed}, {31'b0, exp_sgn});
    check_eq({tag, "_divisor"}, core_if.core_divisor, b);
    check_eq({tag, "_stall_issue"}, {31'b0, stall}, 32'd1);
    tick();
    core_if.core_ready = 1'b0;
    check_eq({tag, "_hs_dividend"}, last_hs_dividend, a);
    for (int i = 0; i < done_wait; i++) begin
      @(negedge clk);
      check_eq({tag, "_stall_wait"}, {31'b0, stall}, 32'd1);
      check_eq({tag, "_req_dropped"}, {31'b0, core_if.core_req}, 32'd0);
      tick();
    end
    core_if.core_done = 1'b1; core_if.core_quotient = q; core_if.core_remainder = r;
    @(negedge clk); check_eq({tag, "_stall_done_cyc"}, {31'b0, stall}, 32'd1);
    tick();
    core_if.core_done = 1'b0; core_if.core_quotient = 32'hdead_beef; core_if.core_remainder = 32'hbad0_bad0;
    exp_q.push_back(exp_res);
    @(negedge clk);
    check_eq({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    check_eq({tag, "_rv"}, {31'b0, result_valid}, 32'd1);
    check_eq({tag, "_result"}, result, exp_res);
    tick();
    ex_valid = 1'b0; ex_is_div = 1'b0;
    check_eq({tag, "_no_reissue"}, {29'b0, dbg_state}, 32'd0);
    check_eq({tag, "_hs_count"}, 32'(hs_count - hs0), 32'd1);
    last_result = exp_res;
  endtask

  // divide-by-zero / overflow: resolved without the core
  task automatic run_special(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res);
    int hs0;
    hs0 = hs_count;
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    core_if.core_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_stall"}, {31'b0, stall}, 32'd1);
    check_eq({tag, "_no_req"}, {31'b0, core_if.core_req}, 32'd0);
    tick();
    exp_q.push_back(exp_res);
    @(negedge clk);
    check_eq({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    check_eq({tag, "_rv"}, {31'b0, result_valid}, 32'd1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_no_req_done"}, {31'b0, core_if.core_req}, 32'd0);
    tick();
    ex_valid = 1'b0; ex_is_div = 1'b0; core_if.core_ready = 1'b0;
    check_eq({tag, "_idle"}, {29'b0, dbg_state}, 32'd0);
    check_eq({tag, "_hs_none"}, 32'(hs_count - hs0), 32'd0);
    last_result = exp_res;
  endtask

  initial begin
    int hs0;
    reset_n = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0; funct3 = 3'b000;
    rs1_val = '0; rs2_val = '0; flush = 1'b0;
    core_if.core_ready = 1'b0; core_if.core_done = 1'b0;
    core_if.core_quotient = '0; core_if.core_remainder = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_rv", {31'b0, result_valid}, 32'd0);
    check_eq("rst_req", {31'b0, core_if.core_req}, 32'd0);
    check_eq("rst_signed", {31'b0, core_if.core_signed}, 32'd0);
    check_eq("rst_dividend", core_if.core_dividend, 32'd0);
    check_eq("rst_divisor", core_if.core_divisor, 32'd0);
    check_eq("rst_state", {29'b0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_core("divu_100_7", 3'b101, 32'd100, 32'd7, 0, 4, 32'd14, 32'd2, 32'd14, 1'b0);
    run_core("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 1, 2,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_special("divu_by0", 3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_special("remu_by0", 3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234);
    run_special("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_special("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_core("b2b_div_7_7", 3'b100, 32'd7, 32'd7, 3, 1, 32'd1, 32'd0, 32'd1, 1'b1);
    run_core("b2b_divu_3_1", 3'b101, 32'd3, 32'd1, 0, 0, 32'd3, 32'd0, 32'd3, 1'b0);

    // funct3[2]=0 (multiply group) must be ignored
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = 3'b001; rs1_val = 32'd5; rs2_val = 32'd3;
    @(negedge clk); check_eq("mul_no_stall", {31'b0, stall}, 32'd0);
    tick();
    check_eq("mul_idle", {29'b0, dbg_state}, 32'd0);
    check_eq("mul_no_req", {31'b0, core_if.core_req}, 32'd0);
    ex_valid = 1'b0; ex_is_div = 1'b0;

    // flush in ISSUE without handshake: request withdrawn, nothing accepted
    hs0 = hs_count;
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = 3'b101; rs1_val = 32'd50; rs2_val = 32'd5;
    tick();
    flush = 1'b1;
    @(negedge clk); check_eq("fl_issue_req", {31'b0, core_if.core_req}, 32'd1);
    tick();
    flush = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;
    check_eq("fl_issue_idle", {29'b0, dbg_state}, 32'd0);
    check_eq("fl_issue_req_off", {31'b0, core_if.core_req}, 32'd0);
    check_eq("fl_issue_hs", 32'(hs_count - hs0), 32'd0);

    // flush in WAIT, done 3 cycles later while a new DIV waits in EX
    hs0 = hs_count;
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = 3'b100; rs1_val = 32'd20; rs2_val = 32'd3;
    core_if.core_ready = 1'b1;
    tick();
    tick();
    core_if.core_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk); check_eq("fl_wait_stall", {31'b0, stall}, 32'd1);
    tick();
    flush = 1'b0; rs1_val = 32'd9; rs2_val = 32'd2;
    @(negedge clk);
    check_eq("drain_stall_1", {31'b0, stall}, 32'd1);
    check_eq("drain_state", {29'b0, dbg_state}, 32'd4);
    tick();
    @(negedge clk); check_eq("drain_stall_2", {31'b0, stall}, 32'd1);
    tick();
    core_if.core_done = 1'b1; core_if.core_quotient = 32'd6; core_if.core_remainder = 32'd2;
    @(negedge clk); check_eq("drain_stall_3", {31'b0, stall}, 32'd1);
    tick();
    core_if.core_done = 1'b0;
    check_eq("drain_idle", {29'b0, dbg_state}, 32'd0);
    check_eq("drain_result_kept", result, last_result);
    check_eq("drain_hs", 32'(hs_count - hs0), 32'd1);
    run_core("div_after_drain", 3'b100, 32'd9, 32'd2, 0, 1, 32'd4, 32'd1, 32'd4, 1'b1);

    // reset_n low in WAIT: everything clears at once, the stale done is ignored
    ex_valid = 1'b1; ex_is_div = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
    core_if.core_ready = 1'b1;
    tick();
    tick();
    core_if.core_ready = 1'b0;
    @(negedge clk); check_eq("rstw_stall_before", {31'b0, stall}, 32'd1);
    #2;
    reset_n = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;
    #1;
    check_eq("rstw_stall", {31'b0, stall}, 32'd0);
    check_eq("rstw_result", result, 32'd0);
    check_eq("rstw_rv", {31'b0, result_valid}, 32'd0);
    check_eq("rstw_req", {31'b0, core_if.core_req}, 32'd0);
    check_eq("rstw_signed", {31'b0, core_if.core_signed}, 32'd0);
    check_eq("rstw_dividend", core_if.core_dividend, 32'd0);
    check_eq("rstw_divisor", core_if.core_divisor, 32'd0);
    check_eq("rstw_state", {29'b0, dbg_state}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    core_if.core_done = 1'b1; core_if.core_quotient = 32'd14; core_if.core_remainder = 32'd2;
    tick();
    core_if.core_done = 1'b0;
    check_eq("rstw_stale_done_idle", {29'b0, dbg_state}, 32'd0);
    check_eq("rstw_stale_result", result, 32'd0);
    tick();

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

EX-stage control unit between the ID/EX pipeline register and the divider core. It decodes the RISC-V M-extension divide/remainder ops (funct3 1xx). It resolves the divide-by-zero and signed-overflow cases locally, and launches every other op to the core with a valid/ready request. It holds the pipeline stalled until the core reports completion, then presents the selected quotient or remainder for exactly one cycle. On that cycle the instruction leaves EX, so the next `ex_is_div` is never mistaken for a re-issue. Flushes abort or drain an in-flight operation.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_is_div  in  1  EX instruction is DIV/DIVU/REM/REMU
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  in  XLEN  dividend
- rs2_val  in  XLEN  divisor
- flush  in  1  kill the EX instruction (redirect)
- stall  out  1  freeze IF/ID/EX (combinational)
- result  out  XLEN  selected quotient/remainder, registered
- result_valid  out  1  one-cycle pulse; `result` is valid
- core_req  out  1  request to divider core
- core_ready  in  1  core accepts request when `core_req`&&`core_ready`
- core_signed  out  1  signed operation
- core_dividend, core_divisor  out  XLEN  latched operands
- core_done  in  1  one-cycle completion pulse from core
- core_quotient, core_remainder  in  XLEN  core results, valid with `core_done`

## Operation
- Launch condition (`go`) = `ex_valid` && `ex_is_div` && `funct3[2]` && !`flush`. `funct3[2]`=0 is ignored: no stall, no request.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - On `go`, latch operands, `core_signed` = !`funct3[0]`, and `is_rem` = `funct3[1]`.
  - Special case, divisor = 0: quotient = all ones, remainder = dividend. Go to DONE with no core request.
  - Special case, signed with dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go to DONE with no core request.
  - Otherwise go to ISSUE.
- ISSUE:
  - `core_req`=1, operands stable.
  - On handshake, go to WAIT.
  - On `flush` without a handshake, go to IDLE. On `flush` with a handshake in the same cycle, go to DRAIN.
- WAIT:
  - On `core_done`, register `result` (remainder if `is_rem`, else quotient) and go to DONE.
  - On `flush`, go to DRAIN. On `flush` with `core_done` in the same cycle, go to IDLE and discard the result.
- DONE:
  - `result_valid` = !`flush`, stall = 0, unconditionally go to IDLE.
  - `go` seen in DONE is not a launch. The next instruction is evaluated in IDLE on the following cycle.
- DRAIN: wait for `core_done`, discard it, go to IDLE.
- `core_done` in IDLE, ISSUE or DONE is ignored.
- `stall` = (IDLE && `go`) || ISSUE || WAIT || (DRAIN && `ex_valid` && `ex_is_div`).

## Timing
- Reset (async assert, sync release): state IDLE, `stall`=0, `result`=0, `result_valid`=0, `core_req`=0, `core_signed`=0, operands 0.
- Reset mid-operation returns the unit to IDLE immediately. A later `core_done` from the old op is ignored.
- Special case: `go` in cycle 0 (stall=1), DONE in cycle 1 (`result_valid`=1, stall=0). EX occupancy is 2 cycles.
- Core path:
  - Cycle 0: IDLE with `go`.
  - Cycle 1: ISSUE. If `core_ready`=1, the handshake completes in this cycle.
  - Cycle 2: WAIT.
  - `core_done` at cycle N gives DONE at N+1.
  - `result` is registered and stable from DONE until the next `core_done` or special-case capture.
- `core_req` and the operands are held constant while ISSUE waits on `core_ready` (AXI-style; no retraction except on flush or reset).
- Exactly one `core_req` handshake and at most one `result_valid` pulse per launched instruction.

## Test plan
- DIVU 100/7, core_done 5 cycles after handshake -> one handshake; `result`=14; `result_valid` high exactly one cycle; `stall` high from launch until the cycle before DONE.
- REM signed: rs1 0xFFFFFFF9 (-7), rs2 2, core returns q 0xFFFFFFFD, r 0xFFFFFFFF -> `result`=0xFFFFFFFF; `core_signed`=1.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234; no `core_req`; stall exactly one cycle each.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; no `core_req`.
- Back-to-back DIV then DIVU, `core_ready` low 3 cycles on the first -> two handshakes in order; two `result_valid` pulses with 1 and 3 respectively for 7/7 and 3/1; no duplicate issue.
- `flush` in WAIT, `core_done` 3 cycles later while a new DIV is in EX -> no `result_valid` for the flushed op; stall held through DRAIN; new op then issues and completes normally. Also `reset_n` low in WAIT -> all outputs 0 at once.
